// File: rtl/tb_uart.sv
// 8N1 UART receive monitor with line tracking and saturating byte/line counters.
// Optional simulation-only console echo when TBUART_DISPLAY_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | timing to start-bit center, rejecting glitches
// S_DATA  | sampling 8 data bits, LSB first
// S_STOP  | timing to stop-bit center
// S_BREAK | stop bit was low, waiting for the line to return high
module tb_uart #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter logic [7:0]  LINE_CHAR    = 8'h0A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ser_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_frame_err,
  output logic        line_done,
  output logic [15:0] byte_count,
  output logic [15:0] line_count,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;

  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        line_done_q, line_done_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic [15:0] line_count_q, line_count_d;
  logic        stop_tick;

  // State register, synchronizer and datapath flops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      line_done_q  <= 1'b0;
      byte_count_q <= '0;
      line_count_q <= '0;
    end else begin
      rx_meta_q    <= ser_rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      line_done_q  <= line_done_d;
      byte_count_q <= byte_count_d;
      line_count_q <= line_count_d;
    end
  end

  // Next-state and bit-timing logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and counter logic; results land one cycle after the stop sample
  always_comb begin
    stop_tick    = (state_q == S_STOP) && (cnt_q == FULL_M1);
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    line_done_d  = 1'b0;
    byte_count_d = byte_count_q;
    line_count_d = line_count_q;
    if (stop_tick && rx_s_q) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      if (byte_count_q != 16'hFFFF) byte_count_d = byte_count_q + 16'd1;
      if (shift_q == LINE_CHAR) begin
        line_done_d = 1'b1;
        if (line_count_q != 16'hFFFF) line_count_d = line_count_q + 16'd1;
      end
    end else if (stop_tick) begin
      frame_err_d = 1'b1;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = frame_err_q;
  assign line_done    = line_done_q;
  assign byte_count   = byte_count_q;
  assign line_count   = line_count_q;
  assign busy         = (state_q != S_IDLE);

`ifdef TBUART_DISPLAY_EN
  always @(posedge clock) begin
    if (!reset) begin
      if (rx_valid_q)  $write("%c", rx_data_q);
      if (line_done_q) $write("tb_uart: line %0d\n", line_count_q);
      if (frame_err_q) $write("tb_uart: framing error\n");
    end
  end
`endif

endmodule

// File: tb/tb_tb_uart.sv
// Directed bench for tb_uart: expected bytes queued at transmit, checked as rx_valid arrives.
module tb_tb_uart;
  localparam int BIT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ser_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_frame_err, line_done, busy;
  logic [15:0] byte_count, line_count;

  int          vectors = 0;
  int          errors  = 0;
  int          valid_seen = 0;
  int          err_seen = 0;
  logic [7:0]  sb[$];
  int          exp_bytes = 0;
  int          exp_lines = 0;
  int          v0, e0;

  tb_uart #(.CLKS_PER_BIT(BIT), .LINE_CHAR(8'h0A)) dut (
    .clock(clock), .reset(reset), .ser_rx(ser_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .line_done(line_done), .byte_count(byte_count), .line_count(line_count),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        valid_seen++;
        if (sb.size() == 0) begin
          check("unexpected_rx_valid", {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e});
          check("line_done", {31'd0, line_done}, {31'd0, (e == 8'h0A)});
        end
      end else if (line_done) begin
        check("stray_line_done", 32'd1, 32'd0);
      end
      if (rx_frame_err) err_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good);
    if (good) begin
      sb.push_back(b);
      if (exp_bytes < 16'hFFFF) exp_bytes++;
      if (b == 8'h0A && exp_lines < 16'hFFFF) exp_lines++;
    end
    ser_rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (BIT) @(negedge clock);
    end
    if (good) begin
      ser_rx = 1'b1;
      repeat (BIT) @(negedge clock);
    end else begin
      ser_rx = 1'b0;
      repeat (2 * BIT) @(negedge clock);
      ser_rx = 1'b1;
      repeat (BIT) @(negedge clock);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 8 * BIT && sb.size() != 0; i++) @(negedge clock);
    check(tag, sb.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_flags"}, {29'd0, rx_valid, rx_frame_err, line_done}, 32'd0);
    check({tag, "_counts"}, {byte_count, line_count}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Reset mid-frame aborts without pulses
    ser_rx = 1'b0;
    repeat (BIT) @(negedge clock);
    ser_rx = 1'b1;
    repeat (2 * BIT) @(negedge clock);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("midframe_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (12 * BIT) @(negedge clock);
    check("after_abort_valid", valid_seen, 32'd0);
    send_byte(8'h41, 1'b1);
    wait_drain("drain_41");
    check("rx_data_41", {24'd0, rx_data}, 32'h41);

    // Single byte
    send_byte(8'hAB, 1'b1);
    wait_drain("drain_ab");
    check("valid_count_ab", valid_seen, 32'd2);
    check("byte_count_ab", {16'd0, byte_count}, exp_bytes);
    check("err_none_ab", err_seen, 32'd0);

    // Line "OK\n" back-to-back
    send_byte(8'h4F, 1'b1);
    send_byte(8'h4B, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_drain("drain_line");
    check("byte_count_line", {16'd0, byte_count}, exp_bytes);
    check("line_count_line", {16'd0, line_count}, exp_lines);
    check("line_count_one", {16'd0, line_count}, 32'd1);

    // Framing error
    v0 = valid_seen;
    send_byte(8'h55, 1'b0);
    repeat (BIT) @(negedge clock);
    check("frame_err_pulse", err_seen, 32'd1);
    check("frame_err_no_valid", valid_seen, v0);
    check("frame_err_rx_data_kept", {24'd0, rx_data}, 32'h0A);
    check("frame_err_count_kept", {16'd0, byte_count}, exp_bytes);
    send_byte(8'h33, 1'b1);
    wait_drain("drain_33");
    check("rx_data_33", {24'd0, rx_data}, 32'h33);

    // Glitch rejected
    v0 = valid_seen;
    e0 = err_seen;
    ser_rx = 1'b0;
    repeat (BIT / 4) @(negedge clock);
    ser_rx = 1'b1;
    repeat (3 * BIT) @(negedge clock);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_valid", valid_seen, v0);
    check("glitch_err", err_seen, e0);
    check("glitch_byte_count", {16'd0, byte_count}, exp_bytes);

    // Saturation
    force dut.byte_count_q = 16'hFFFE;
    @(negedge clock);
    release dut.byte_count_q;
    exp_bytes = 16'hFFFE;
    @(negedge clock);
    check("sat_preload", {16'd0, byte_count}, exp_bytes);
    send_byte(8'h61, 1'b1);
    wait_drain("drain_sat1");
    check("sat_1", {16'd0, byte_count}, exp_bytes);
    send_byte(8'h62, 1'b1);
    wait_drain("drain_sat2");
    check("sat_2", {16'd0, byte_count}, exp_bytes);
    send_byte(8'h63, 1'b1);
    wait_drain("drain_sat3");
    check("sat_3", {16'd0, byte_count}, 32'hFFFF);
    check("final_line_count", {16'd0, line_count}, exp_lines);
    check("final_err_count", err_seen, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
